out_nibble_packer: RTL and testbench

OUT_NIBBLE_PACKER -- requirements
Module: out_nibble_packer

---
 rtl/out_nibble_packer_pkg.sv | 24 ++
 rtl/out_pack_fifo.sv | 80 ++++++++
 rtl/out_nibble_packer.sv | 92 +++++++++
 tb/tb_out_nibble_packer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_nibble_packer_pkg.sv
// Shared fabric constants for the output nibble packer.
//   NIBBLE_W          width of one incoming nibble
//   WORD_W            width of one packed word
//   NIBBLES_PER_WORD  nibbles assembled into each word
//   CFG_EN/CFG_ORDER  bit positions inside ConfigBits
//   slot_of()         maps nibble index k to its slot for a given order
package out_nibble_packer_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 16;
  localparam int NIBBLES_PER_WORD = 4;
  localparam int CNT_W            = $clog2(NIBBLES_PER_WORD);

  localparam int CFG_EN    = 0;
  localparam int CFG_ORDER = 1;

  // Order 0 places nibble k in slot k; order 1 places it in slot 3-k,
  // which for a 2-bit index is simply the bitwise complement.
  function automatic logic [CNT_W-1:0] slot_of(input logic [CNT_W-1:0] k,
                                               input logic             order);
    return order ? ~k : k;
  endfunction

endpackage

// File: rtl/out_pack_fifo.sv
// Word FIFO for the nibble packer with a registered head output.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i        write push_data_i (accepted when not full, or full with pop)
//   pop_i         remove the head (ignored when empty)
//   full_o        DEPTH entries held
//   empty_o       no entries held
//   head_o        registered copy of the oldest entry (0 after reset)
module out_pack_fifo
  import out_nibble_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [WORD_W-1:0] head_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic              push_ok, pop_ok;

  // Pointers carry one wrap bit above the index: equal indices mean empty
  // when the wrap bits match and full when they differ.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  // A push while full is accepted only if the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    head_d   = head_q;
    // Preload the entry that will be at the head after this edge. If that
    // slot is the one being written now, take the incoming word directly.
    if (wr_ptr_d != rd_ptr_d) begin
      if (push_ok && (rd_ptr_d[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0])) begin
        head_d = push_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d[IDX_W-1:0]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end
  end

  assign head_o = head_q;

endmodule

// File: rtl/out_nibble_packer.sv
// Output nibble packer BEL: assembles four nibbles into a 16-bit word and
// queues completed words for an external consumer.
//   UserCLK     fabric user clock (rising edge)
//   Reset       asynchronous active-high reset, flushes everything
//   I, I_valid  incoming nibble and its strobe
//   D, D_valid  FIFO head word and non-empty flag
//   D_ready     consumer accepts D when D_valid is also high
//   Overflow    sticky, set when a completed word is dropped
//   ConfigBits  [0] enable, [1] nibble order
(* FABulous, BelMap, EN=0, ORDER=1 *)
module out_nibble_packer
  import out_nibble_packer_pkg::*;
#(
  parameter int NoConfigBits = 2,
  parameter int DEPTH        = 4
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic [NIBBLE_W-1:0]     I,
  input  logic                    I_valid,
  (* FABulous, EXTERNAL *) output logic [WORD_W-1:0] D,
  (* FABulous, EXTERNAL *) output logic              D_valid,
  (* FABulous, EXTERNAL *) input  logic              D_ready,
  (* FABulous, EXTERNAL *) output logic              Overflow,
  (* FABulous, GLOBAL *)   input  logic [NoConfigBits-1:0] ConfigBits
);

  logic              en, order;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              overflow_q, overflow_d;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  slot;

  assign en     = ConfigBits[CFG_EN];
  assign order  = ConfigBits[CFG_ORDER];
  assign accept = I_valid && en;
  // Order is sampled per nibble, so a mid-word change only moves later nibbles.
  assign slot   = slot_of(cnt_q, order);
  assign push   = accept && (cnt_q == CNT_W'(NIBBLES_PER_WORD - 1));
  assign pop    = D_valid && D_ready;

  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    overflow_d = overflow_q;
    if (!en) begin
      // Disabling abandons the partial word; queued words keep draining.
      cnt_d = '0;
      asm_d = '0;
    end else if (accept) begin
      // Counter wraps 3 -> 0, which also restarts after a dropped word.
      cnt_d = cnt_q + CNT_W'(1);
      asm_d[int'(slot)*NIBBLE_W +: NIBBLE_W] = I;
    end
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

  // asm_d already contains the 4th nibble, so the full word is pushed on
  // the same edge that nibble is accepted.
  out_pack_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (UserCLK),
    .rst_i      (Reset),
    .push_i     (push),
    .push_data_i(asm_d),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (D)
  );

  assign D_valid  = !fifo_empty;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_out_nibble_packer.sv
module tb_out_nibble_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  I = '0;
  logic        I_valid = 1'b0;
  logic [15:0] D;
  logic        D_valid;
  logic        D_ready = 1'b0;
  logic        Overflow;
  logic [1:0]  ConfigBits = 2'b00;

  int total = 0;
  int bad   = 0;

  // Behavioural model: queues of words and of pending nibbles.
  logic [15:0] m_words[$];
  logic [3:0]  m_nibs[$];
  bit          m_ords[$];
  bit          m_ovf = 1'b0;

  out_nibble_packer #(
    .NoConfigBits(2),
    .DEPTH(DEPTH)
  ) dut (
    .UserCLK   (clk),
    .Reset     (rst),
    .I         (I),
    .I_valid   (I_valid),
    .D         (D),
    .D_valid   (D_valid),
    .D_ready   (D_ready),
    .Overflow  (Overflow),
    .ConfigBits(ConfigBits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the specification's rules.
  always @(posedge clk or posedge rst) begin
    bit          pop_now, was_full;
    logic [15:0] w;
    if (rst) begin
      m_words.delete();
      m_nibs.delete();
      m_ords.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (m_words.size() == DEPTH);
      pop_now  = (m_words.size() > 0) && D_ready;
      if (pop_now) void'(m_words.pop_front());
      if (!ConfigBits[0]) begin
        m_nibs.delete();
        m_ords.delete();
      end else if (I_valid) begin
        m_nibs.push_back(I);
        m_ords.push_back(ConfigBits[1]);
        if (m_nibs.size() == 4) begin
          w = '0;
          for (int k = 0; k < 4; k++) begin
            w = w | (16'(m_nibs[k]) << (4 * (m_ords[k] ? 3 - k : k)));
          end
          if (was_full && !pop_now) m_ovf = 1'b1;
          else m_words.push_back(w);
          m_nibs.delete();
          m_ords.delete();
        end
      end
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_dvalid", 16'(D_valid), 16'(m_words.size() > 0));
      if (m_words.size() > 0) check("model_data", D, m_words[0]);
      check("model_ovf", 16'(Overflow), 16'(m_ovf));
    end
  end

  task automatic drive(input logic v, input logic [3:0] n, input logic [1:0] cfg, input logic rdy);
    @(negedge clk);
    I_valid    = v;
    I          = n;
    ConfigBits = cfg;
    D_ready    = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 4'h0, 2'b01, rdy);
  endtask

  // Sends a word with order 0, nibble k taken from bits [4k+3:4k].
  task automatic send_word(input logic [15:0] w, input logic rdy);
    for (int k = 0; k < 4; k++) drive(1'b1, w[4*k +: 4], 2'b01, rdy);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [15:0] d);
    check({name, "_valid"}, 16'(D_valid), 16'(v));
    if (v) check({name, "_data"}, D, d);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_dvalid", 16'(D_valid), 16'h0);
    check("rst_ovf", 16'(Overflow), 16'h0);
    check("rst_d", D, 16'h0000);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  logic [15:0] words[5];

  initial begin
    #1;
    check("por_dvalid", 16'(D_valid), 16'h0);
    check("por_d", D, 16'h0000);
    check("por_ovf", 16'(Overflow), 16'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    // Order 0: nibbles 1,2,3,4 -> 4321, valid for exactly one cycle.
    drive(1'b1, 4'h1, 2'b01, 1'b1);
    drive(1'b1, 4'h2, 2'b01, 1'b1);
    drive(1'b1, 4'h3, 2'b01, 1'b1);
    drive(1'b1, 4'h4, 2'b01, 1'b1);
    idle(1'b1);
    expect_out("ord0", 1'b1, 16'h4321);
    idle(1'b1);
    expect_out("ord0_gone", 1'b0, 16'h0);

    // Order 1: same nibbles -> 1234.
    drive(1'b1, 4'h1, 2'b11, 1'b1);
    drive(1'b1, 4'h2, 2'b11, 1'b1);
    drive(1'b1, 4'h3, 2'b11, 1'b1);
    drive(1'b1, 4'h4, 2'b11, 1'b1);
    idle(1'b1);
    expect_out("ord1", 1'b1, 16'h1234);
    idle(1'b1);
    expect_out("ord1_gone", 1'b0, 16'h0);

    // Five words with consumer stalled: fifth is dropped.
    words[0] = 16'hA5C3;
    words[1] = 16'h1234;
    words[2] = 16'hBEEF;
    words[3] = 16'h0F0F;
    words[4] = 16'h7777;
    for (int i = 0; i < 5; i++) send_word(words[i], 1'b0);
    idle(1'b0);
    expect_out("ovf_head", 1'b1, 16'hA5C3);
    check("ovf_set", 16'(Overflow), 16'h1);
    idle(1'b0);
    expect_out("ovf_hold", 1'b1, 16'hA5C3);
    idle(1'b1);
    expect_out("drain0", 1'b1, 16'hA5C3);
    idle(1'b1);
    expect_out("drain1", 1'b1, 16'h1234);
    idle(1'b1);
    expect_out("drain2", 1'b1, 16'hBEEF);
    idle(1'b1);
    expect_out("drain3", 1'b1, 16'h0F0F);
    idle(1'b1);
    expect_out("drain_empty", 1'b0, 16'h0);
    check("ovf_sticky", 16'(Overflow), 16'h1);

    // Full FIFO, 4th nibble of a new word coincides with a pop.
    pulse_reset();
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    send_word(16'h4444, 1'b0);
    drive(1'b1, 4'h6, 2'b01, 1'b0);
    drive(1'b1, 4'h7, 2'b01, 1'b0);
    drive(1'b1, 4'h8, 2'b01, 1'b0);
    drive(1'b1, 4'h9, 2'b01, 1'b1);
    idle(1'b1);
    check("pp_no_ovf", 16'(Overflow), 16'h0);
    expect_out("pp0", 1'b1, 16'h2222);
    idle(1'b1);
    expect_out("pp1", 1'b1, 16'h3333);
    idle(1'b1);
    expect_out("pp2", 1'b1, 16'h4444);
    idle(1'b1);
    expect_out("pp3", 1'b1, 16'h9876);
    idle(1'b1);
    expect_out("pp_empty", 1'b0, 16'h0);

    // Partial word discarded by a one-cycle enable drop.
    drive(1'b1, 4'h5, 2'b01, 1'b1);
    drive(1'b1, 4'h6, 2'b01, 1'b1);
    drive(1'b1, 4'hE, 2'b00, 1'b1);
    drive(1'b1, 4'hA, 2'b01, 1'b1);
    drive(1'b1, 4'hB, 2'b01, 1'b1);
    drive(1'b1, 4'hC, 2'b01, 1'b1);
    drive(1'b1, 4'hD, 2'b01, 1'b1);
    idle(1'b1);
    expect_out("en_drop", 1'b1, 16'hDCBA);
    idle(1'b1);
    expect_out("en_drop_gone", 1'b0, 16'h0);

    // Reset mid-word with two words queued: full flush.
    send_word(16'hCAFE, 1'b0);
    send_word(16'hF00D, 1'b0);
    drive(1'b1, 4'h3, 2'b01, 1'b0);
    drive(1'b1, 4'h5, 2'b01, 1'b0);
    idle(1'b0);
    expect_out("pre_rst", 1'b1, 16'hCAFE);
    pulse_reset();
    drive(1'b1, 4'h4, 2'b01, 1'b1);
    drive(1'b1, 4'h3, 2'b01, 1'b1);
    drive(1'b1, 4'h2, 2'b01, 1'b1);
    drive(1'b1, 4'h1, 2'b01, 1'b1);
    idle(1'b1);
    expect_out("post_rst", 1'b1, 16'h1234);
    check("post_rst_ovf", 16'(Overflow), 16'h0);
    idle(1'b1);
    expect_out("post_rst_gone", 1'b0, 16'h0);

    idle(1'b1);
    idle(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
